// File: rtl/cordic_linear_sched.sv
// rtl/cordic_linear_sched.sv - round-robin scheduler sharing one cordic_linear core
//
// Purpose: accepts one operation at a time from NUM_REQ requesters (valid/ready),
// drives the core start/done protocol, returns results to the originating lane,
// and answers with an error response if the core never signals done.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/req_ready      per-lane request handshake (req_ready at most one-hot)
//   req_x/req_y/req_z        flattened lane operands, lane i at [i*W +: W]
//   req_mode                 per-lane mode (1 = vectoring/divide, 0 = rotation/multiply)
//   rsp_valid/rsp_ready      per-lane response handshake (rsp_valid one-hot of owner)
//   rsp_x/rsp_y/rsp_z        shared result bus
//   rsp_err                  response is a watchdog timeout
//   core_start               single-cycle start pulse to the core
//   core_x/y/z, core_mode    registered operands to the core
//   core_x/y/z_out,core_done core results and completion
//   busy                     high whenever the scheduler is not idle
module cordic_linear_sched #(
  parameter int FLOAT_SIZE = 24,
  parameter int INT_SIZE   = 8,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_REQ-1:0]                        req_valid,
  output logic [NUM_REQ-1:0]                        req_ready,
  input  logic [NUM_REQ*(INT_SIZE+FLOAT_SIZE)-1:0]  req_x,
  input  logic [NUM_REQ*(INT_SIZE+FLOAT_SIZE)-1:0]  req_y,
  input  logic [NUM_REQ*(INT_SIZE+FLOAT_SIZE)-1:0]  req_z,
  input  logic [NUM_REQ-1:0]                        req_mode,
  output logic [NUM_REQ-1:0]                        rsp_valid,
  input  logic [NUM_REQ-1:0]                        rsp_ready,
  output logic [INT_SIZE+FLOAT_SIZE-1:0]            rsp_x,
  output logic [INT_SIZE+FLOAT_SIZE-1:0]            rsp_y,
  output logic [INT_SIZE+FLOAT_SIZE-1:0]            rsp_z,
  output logic                                      rsp_err,
  output logic                                      core_start,
  output logic [INT_SIZE+FLOAT_SIZE-1:0]            core_x,
  output logic [INT_SIZE+FLOAT_SIZE-1:0]            core_y,
  output logic [INT_SIZE+FLOAT_SIZE-1:0]            core_z,
  output logic                                      core_mode,
  input  logic [INT_SIZE+FLOAT_SIZE-1:0]            core_x_out,
  input  logic [INT_SIZE+FLOAT_SIZE-1:0]            core_y_out,
  input  logic [INT_SIZE+FLOAT_SIZE-1:0]            core_z_out,
  input  logic                                      core_done,
  output logic                                      busy
);

  localparam int W   = INT_SIZE + FLOAT_SIZE;
  localparam int PW  = $clog2(NUM_REQ);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_RESP
  } state_t;

  state_t          state;
  logic [PW-1:0]   p;
  logic [PW-1:0]   owner;
  logic [WDW-1:0]  wd;

  logic [PW-1:0]       grant;
  logic                any_valid;
  logic [PW:0]         scan;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [NUM_REQ-1:0]  owner_oh;
  logic [PW-1:0]       owner_next;

  // Scan from the highest offset down so the lane closest to p is the one left standing.
  always_comb begin
    grant     = p;
    any_valid = 1'b0;
    scan      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan = {1'b0, p} + (PW+1)'(k);
      if (scan >= (PW+1)'(NUM_REQ)) begin
        scan = scan - (PW+1)'(NUM_REQ);
      end
      if (req_valid[scan[PW-1:0]]) begin
        grant     = scan[PW-1:0];
        any_valid = 1'b1;
      end
    end
  end

  assign grant_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;
  assign owner_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
  assign owner_next = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + PW'(1);

  // Gated by rst so nothing is offered while reset is held, even with state already IDLE.
  assign req_ready = (rst && state == S_IDLE && any_valid) ? grant_oh : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      p          <= '0;
      owner      <= '0;
      wd         <= '0;
      busy       <= 1'b0;
      core_start <= 1'b0;
      core_x     <= '0;
      core_y     <= '0;
      core_z     <= '0;
      core_mode  <= 1'b0;
      rsp_valid  <= '0;
      rsp_x      <= '0;
      rsp_y      <= '0;
      rsp_z      <= '0;
      rsp_err    <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            core_x     <= req_x[32'(grant)*W +: W];
            core_y     <= req_y[32'(grant)*W +: W];
            core_z     <= req_z[32'(grant)*W +: W];
            core_mode  <= req_mode[grant];
            owner      <= grant;
            core_start <= 1'b1;
            busy       <= 1'b1;
            state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          wd    <= '0;
          state <= S_BUSY;
        end
        S_BUSY: begin
          wd <= wd + WDW'(1);
          // done is checked first so a completion on the timeout cycle still wins.
          if (core_done) begin
            rsp_x     <= core_x_out;
            rsp_y     <= core_y_out;
            rsp_z     <= core_z_out;
            rsp_err   <= 1'b0;
            rsp_valid <= owner_oh;
            state     <= S_RESP;
          end else if (wd == WDW'(TIMEOUT - 1)) begin
            rsp_x     <= '0;
            rsp_y     <= '0;
            rsp_z     <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= owner_oh;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            p         <= owner_next;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_linear_sched.sv
// tb/tb_cordic_linear_sched.sv - directed self-checking bench for cordic_linear_sched
module tb_cordic_linear_sched;

  localparam int F  = 24;
  localparam int IS = 8;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready, req_mode, rsp_valid, rsp_ready;
  logic [N*W-1:0]   req_x, req_y, req_z;
  logic [W-1:0]     rsp_x, rsp_y, rsp_z;
  logic             rsp_err, core_start, core_mode, core_done, busy;
  logic [W-1:0]     core_x, core_y, core_z;
  logic [W-1:0]     core_x_out, core_y_out, core_z_out;

  int   lat;
  bit   hang;
  logic force_done;
  logic stub_done, stub_act;
  int   stub_cnt;
  int   total = 0;
  int   passed = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  cordic_linear_sched #(
    .FLOAT_SIZE(F), .INT_SIZE(IS), .NUM_REQ(N), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_mode(req_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z), .rsp_err(rsp_err),
    .core_start(core_start), .core_x(core_x), .core_y(core_y), .core_z(core_z),
    .core_mode(core_mode),
    .core_x_out(core_x_out), .core_y_out(core_y_out), .core_z_out(core_z_out),
    .core_done(core_done), .busy(busy)
  );

  // Ideal linear core: divide in vectoring mode, multiply-accumulate in rotation mode.
  function automatic logic [3*W-1:0] cmodel(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [W-1:0] z, input logic m);
    longint sx, sy, sz;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    sz = longint'(signed'(z));
    if (m) begin
      if (sx == 0) return {x, {W{1'b0}}, z};
      return {x, {W{1'b0}}, W'(sz + ((sy <<< F) / sx))};
    end
    return {x, W'(sy + ((sx * sz) >>> F)), {W{1'b0}}};
  endfunction

  assign core_done = stub_done | force_done;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stub_done  <= 1'b0;
      stub_act   <= 1'b0;
      stub_cnt   <= 0;
      core_x_out <= '0;
      core_y_out <= '0;
      core_z_out <= '0;
    end else begin
      stub_done <= 1'b0;
      if (core_start) begin
        {core_x_out, core_y_out, core_z_out} <= cmodel(core_x, core_y, core_z, core_mode);
        if (lat <= 1) begin
          stub_done <= !hang;
        end else begin
          stub_act <= 1'b1;
          stub_cnt <= lat - 1;
        end
      end else if (stub_act) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) begin
          stub_act  <= 1'b0;
          stub_done <= !hang;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int l, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] z, input logic m);
    req_x[l*W +: W] = x;
    req_y[l*W +: W] = y;
    req_z[l*W +: W] = z;
    req_mode[l]     = m;
    req_valid[l]    = 1'b1;
  endtask

  // Returns the granted lane; on return the bench sits in cycle 1 (LAUNCH).
  task automatic accept(output int gl);
    int n;
    n  = 0;
    gl = -1;
    #1;
    while (req_ready == '0 && n < 40) begin
      tick;
      n++;
    end
    for (int i = 0; i < N; i++) if (req_ready[i]) gl = i;
    if (gl < 0) begin
      total++;
      fails++;
      $error("FAIL accept_bound: req_ready stayed 0x%0h for %0d cycles", req_ready, n);
      gl = 0;
    end
    tick;
    req_valid[gl] = 1'b0;
  endtask

  // Cycle index at which rsp_valid first reads nonzero, counting the LAUNCH cycle as 1.
  task automatic await_rsp(output int cyc, output int starts);
    cyc    = 1;
    starts = int'(core_start);
    while (rsp_valid == '0 && cyc < 60) begin
      tick;
      cyc++;
      starts += int'(core_start);
    end
  endtask

  task automatic ack(input int l);
    rsp_ready    = '0;
    rsp_ready[l] = 1'b1;
    tick;
    rsp_ready    = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gl, cyc, starts, bad;
    logic [W-1:0] sx, sy, sz;
    logic [N-1:0] sv;

    req_valid = '0; req_mode = '0; req_x = '0; req_y = '0; req_z = '0;
    rsp_ready = '0; force_done = 1'b0; lat = 3; hang = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;

    // Reset state, with a lane already requesting.
    set_req(0, 32'h0180_0000, 32'h0100_0000, 32'h0, 1'b1);
    tick; tick;
    chk("reset_req_ready", req_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_core", {core_start, core_mode, core_x, core_y, core_z}, 0);
    chk("reset_rsp", {rsp_err, rsp_x, rsp_y, rsp_z}, 0);
    rst = 1'b1;

    // Single divide request on lane 0.
    accept(gl);
    chk("t1_grant", gl, 0);
    chk("t1_core_ops", {core_mode, core_x, core_y}, {1'b1, 32'h0180_0000, 32'h0100_0000});
    chk("t1_busy", busy, 1);
    await_rsp(cyc, starts);
    chk("t1_latency", cyc, 5);
    chk("t1_one_start", starts, 1);
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_rsp_err", rsp_err, 0);
    chk("t1_rsp_z_near", (rsp_z >= 32'h00AA_AAA6) && (rsp_z <= 32'h00AA_AAAE), 1);
    ack(0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_rsp_valid", rsp_valid, 0);

    // All four lanes from reset, rsp_ready tied high: grants 0,1,2,3.
    rst = 1'b0; tick; rst = 1'b1;
    lat = 1;
    rsp_ready = 4'hF;
    for (int i = 0; i < N; i++) set_req(i, W'(i + 1) << F, 32'h0, 32'h0100_0000, 1'b0);
    for (int i = 0; i < N; i++) begin
      accept(gl);
      chk("t2_grant", gl, i);
      await_rsp(cyc, starts);
      chk("t2_rsp_valid", rsp_valid, 4'b0001 << i);
      chk("t2_rsp_y", rsp_y, W'(i + 1) << F);
      tick;
    end
    set_req(0, 32'h0100_0000, 32'h0, 32'h0100_0000, 1'b0);
    accept(gl);
    chk("t2_regrant0", gl, 0);
    await_rsp(cyc, starts);
    tick;
    set_req(1, 32'h0100_0000, 32'h0, 32'h0100_0000, 1'b0);
    set_req(3, 32'h0100_0000, 32'h0, 32'h0100_0000, 1'b0);
    accept(gl);
    chk("t2_reraise_first", gl, 1);
    await_rsp(cyc, starts);
    tick;
    set_req(0, 32'h0100_0000, 32'h0, 32'h0100_0000, 1'b0);
    accept(gl);
    chk("t2_reraise_second", gl, 3);
    await_rsp(cyc, starts);
    tick;
    accept(gl);
    chk("t2_wrap_grant", gl, 0);
    await_rsp(cyc, starts);
    tick;

    // Backpressure on lane 2 while lanes 0 and 1 wait.
    rsp_ready = '0;
    lat = 2;
    set_req(2, 32'h0300_0000, 32'h0000_1234, 32'h0040_0000, 1'b0);
    accept(gl);
    chk("t3_grant", gl, 2);
    set_req(0, 32'h0200_0000, 32'h0, 32'h0100_0000, 1'b0);
    set_req(1, 32'h0400_0000, 32'h0, 32'h0100_0000, 1'b0);
    await_rsp(cyc, starts);
    chk("t3_rsp_y", rsp_y, 32'h00C0_1234);
    sv = rsp_valid; sx = rsp_x; sy = rsp_y; sz = rsp_z;
    rsp_ready = 4'b1011;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (rsp_valid !== sv || rsp_x !== sx || rsp_y !== sy || rsp_z !== sz ||
          req_ready !== '0 || core_start !== 1'b0) bad++;
    end
    chk("t3_hold_stable", bad, 0);
    chk("t3_hold_valid", rsp_valid, 4'b0100);
    rsp_ready = 4'b0100;
    tick;
    chk("t3_release_valid", rsp_valid, 0);
    chk("t3_release_busy", busy, 0);
    rsp_ready = 4'hF;
    accept(gl);
    chk("t3_next_grant", gl, 0);
    await_rsp(cyc, starts);
    chk("t3_next_rsp_y", rsp_y, 32'h0200_0000);
    tick;
    accept(gl);
    chk("t3_after_grant", gl, 1);
    await_rsp(cyc, starts);
    tick;

    // Core that never finishes.
    rsp_ready = '0;
    hang = 1'b1;
    set_req(3, 32'h0000_0005, 32'h0000_0006, 32'h0000_0007, 1'b0);
    accept(gl);
    chk("t4_grant", gl, 3);
    await_rsp(cyc, starts);
    chk("t4_timeout_latency", cyc, 10);
    chk("t4_rsp_valid", rsp_valid, 4'b1000);
    chk("t4_rsp_err", rsp_err, 1);
    chk("t4_rsp_data", {rsp_x, rsp_y, rsp_z}, 0);
    ack(3);
    hang = 1'b0;
    lat = 2;
    set_req(0, 32'h0200_0000, 32'h0, 32'h0080_0000, 1'b0);
    accept(gl);
    chk("t4_follow_grant", gl, 0);
    await_rsp(cyc, starts);
    chk("t4_follow_latency", cyc, 4);
    chk("t4_follow_err", rsp_err, 0);
    chk("t4_follow_y", rsp_y, 32'h0100_0000);
    ack(0);

    // Spurious done in IDLE.
    force_done = 1'b1; tick; force_done = 1'b0; tick;
    chk("t5_idle_done", {busy, core_start, rsp_valid}, 0);

    // done lands exactly on the timeout cycle.
    lat = 8;
    set_req(1, 32'h0100_0000, 32'h0080_0000, 32'h0010_0000, 1'b1);
    accept(gl);
    chk("t5_tie_grant", gl, 1);
    await_rsp(cyc, starts);
    chk("t5_tie_latency", cyc, 10);
    chk("t5_tie_err", rsp_err, 0);
    chk("t5_tie_z", rsp_z, 32'h0090_0000);
    ack(1);

    // One cycle late: timeout wins, and the late done plus a forced one hit RESP.
    lat = 9;
    set_req(2, 32'h0100_0000, 32'h0, 32'h0100_0000, 1'b0);
    accept(gl);
    await_rsp(cyc, starts);
    chk("t5_late_err", rsp_err, 1);
    tick;
    force_done = 1'b1; tick; force_done = 1'b0; tick;
    chk("t5_resp_done_valid", {rsp_valid, rsp_err}, {4'b0100, 1'b1});
    ack(2);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid !== '0 || busy !== 1'b0) bad++;
      tick;
    end
    chk("t5_no_extra_rsp", bad, 0);

    // Reset in BUSY abandons the job; pointer restarts at 0.
    lat = 20;
    set_req(1, 32'h0100_0000, 32'h0, 32'h0100_0000, 1'b0);
    accept(gl);
    tick; tick;
    chk("t6_in_busy", busy, 1);
    set_req(2, 32'h3F7A_E147, 32'h0, 32'h0100_0000, 1'b0);
    set_req(3, 32'h0100_0000, 32'h0, 32'h0100_0000, 1'b0);
    rst = 1'b0;
    #1;
    chk("t6_rst_req_ready", req_ready, 0);
    chk("t6_rst_ctl", {busy, core_start, rsp_valid, rsp_err}, 0);
    chk("t6_rst_data", {core_mode, core_x, core_y, core_z, rsp_x, rsp_y, rsp_z}, 0);
    tick;
    rst = 1'b1;
    lat = 3;
    accept(gl);
    chk("t6_grant", gl, 2);
    chk("t6_core_x", core_x, 32'h3F7A_E147);
    await_rsp(cyc, starts);
    chk("t6_latency", cyc, 5);
    chk("t6_rsp", {rsp_valid, rsp_err, rsp_y}, {4'b0100, 1'b0, 32'h3F7A_E147});
    ack(2);
    accept(gl);
    chk("t6_next_grant", gl, 3);
    await_rsp(cyc, starts);
    ack(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
